// File: rtl/ram_dma_copier.sv
// Word-by-word memory copier driving one port of a byte-addressed RAM.
// Each word is read (combinational RAM read) and then written, gated by gnt_i.
module ram_dma_copier #(
    parameter int MEM_WIDTH = 1048576,
    parameter int LEN_WIDTH = 16,
    localparam int AW = $clog2(MEM_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [AW-1:0]        src_i,
    input  logic [AW-1:0]        dst_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    input  logic                 gnt_i,
    output logic                 mem_en_o,
    output logic [3:0]           mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] count_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        src_q, dst_q;
    logic [LEN_WIDTH-1:0] rem_q, count_q;
    logic [31:0]          buf_q;
    logic                 err_q;
    logic                 misaligned, start_ok, word_done;

    // Handshake: an access is presented whenever mem_en_o is high and takes
    // effect only on an edge where gnt_i is high; otherwise it is held unchanged.
    assign misaligned = (src_i[1:0] != 2'b00) || (dst_i[1:0] != 2'b00);
    assign start_ok   = (state == IDLE) && start_i && !misaligned && (len_i != '0);
    assign word_done  = (state == WRITE) && gnt_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i && !misaligned) begin
                    state_nxt = (len_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (abort_i)    state_nxt = IDLE;
                else if (gnt_i) state_nxt = WRITE;
            end
            WRITE: begin
                // Abort wins, but a granted write still commits at this edge.
                if (abort_i)    state_nxt = IDLE;
                else if (gnt_i) state_nxt = (rem_q == LEN_WIDTH'(1)) ? DONE : READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en_o   = 1'b0;
        mem_we_o   = 4'h0;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state)
            READ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = src_q;
            end
            WRITE: begin
                mem_en_o   = 1'b1;
                mem_we_o   = 4'hF;
                mem_addr_o = dst_q;
                mem_data_o = buf_q;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);
    assign err_o   = err_q;
    assign count_o = count_q;
    assign state_o = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start_i && misaligned;
            if (start_ok) begin
                src_q   <= src_i;
                dst_q   <= dst_i;
                rem_q   <= len_i;
                count_q <= '0;
            end
            if ((state == READ) && gnt_i && !abort_i) begin
                buf_q <= mem_data_i;
            end
            // Addresses wrap silently at the top of the RAM.
            if (word_done) begin
                src_q   <= src_q + AW'(4);
                dst_q   <= dst_q + AW'(4);
                rem_q   <= rem_q - LEN_WIDTH'(1);
                count_q <= count_q + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_dma_copier.sv
// Bench for ram_dma_copier: a 1 MiB instance and a 256-byte instance share
// one stimulus stream, each attached to its own byte RAM and reference image.
module tb_ram_dma_copier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, gnt;
    logic [19:0] src, dst;
    logic [15:0] len;

    logic        b_en, b_busy, b_done, b_err;
    logic [3:0]  b_we;
    logic [19:0] b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [15:0] b_count;
    logic [1:0]  b_state;

    logic        s_en, s_busy, s_done, s_err;
    logic [3:0]  s_we;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic [15:0] s_count;
    logic [1:0]  s_state;

    logic        pl_we;
    logic [19:0] pl_addr;
    logic [31:0] pl_word;

    logic [7:0]  ram_b [0:1048575];
    logic [7:0]  ram_s [0:255];
    logic [7:0]  exp_b [0:1048575];
    logic [7:0]  exp_s [0:255];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ram_dma_copier u_big (
        .clk(clk), .reset_n(reset_n), .start_i(start), .src_i(src), .dst_i(dst),
        .len_i(len), .abort_i(abort), .gnt_i(gnt), .mem_en_o(b_en), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_data_o(b_wdata), .mem_data_i(b_rdata),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .count_o(b_count),
        .state_o(b_state)
    );

    ram_dma_copier #(.MEM_WIDTH(256)) u_small (
        .clk(clk), .reset_n(reset_n), .start_i(start), .src_i(src[7:0]), .dst_i(dst[7:0]),
        .len_i(len), .abort_i(abort), .gnt_i(gnt), .mem_en_o(s_en), .mem_we_o(s_we),
        .mem_addr_o(s_addr), .mem_data_o(s_wdata), .mem_data_i(s_rdata),
        .busy_o(s_busy), .done_o(s_done), .err_o(s_err), .count_o(s_count),
        .state_o(s_state)
    );

    // Little-endian byte RAMs with combinational read; a granted access commits at the edge.
    always_comb b_rdata = {ram_b[b_addr + 20'd3], ram_b[b_addr + 20'd2], ram_b[b_addr + 20'd1], ram_b[b_addr]};
    always_comb s_rdata = {ram_s[s_addr + 8'd3], ram_s[s_addr + 8'd2], ram_s[s_addr + 8'd1], ram_s[s_addr]};

    always @(posedge clk) begin
        if (pl_we) begin
            for (int i = 0; i < 4; i++) begin
                ram_b[pl_addr + 20'(i)]      <= pl_word[8*i +: 8];
                ram_s[pl_addr[7:0] + 8'(i)]  <= pl_word[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (b_en && gnt && b_we[i]) ram_b[b_addr + 20'(i)] <= b_wdata[8*i +: 8];
                if (s_en && gnt && s_we[i]) ram_s[s_addr + 8'(i)]  <= s_wdata[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference memory image: plain byte arrays, copy = ascending word moves.
    function automatic logic [31:0] word_b(input logic [19:0] a);
        return {exp_b[a + 20'd3], exp_b[a + 20'd2], exp_b[a + 20'd1], exp_b[a]};
    endfunction

    function automatic logic [31:0] word_s(input logic [7:0] a);
        return {exp_s[a + 8'd3], exp_s[a + 8'd2], exp_s[a + 8'd1], exp_s[a]};
    endfunction

    function automatic void model_write(input logic [19:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_b[a + 20'(i)]     = w[8*i +: 8];
            exp_s[a[7:0] + 8'(i)] = w[8*i +: 8];
        end
    endfunction

    function automatic void model_copy(input logic [19:0] s, input logic [19:0] d, input int n);
        logic [31:0] w;
        logic [19:0] sa, da;
        logic [7:0]  ss, ds;
        for (int k = 0; k < n; k++) begin
            sa = s + 20'(4 * k);
            da = d + 20'(4 * k);
            w  = word_b(sa);
            for (int i = 0; i < 4; i++) exp_b[da + 20'(i)] = w[8*i +: 8];
            ss = sa[7:0];
            ds = da[7:0];
            w  = word_s(ss);
            for (int i = 0; i < 4; i++) exp_s[ds + 8'(i)] = w[8*i +: 8];
        end
    endfunction

    task automatic preload(input logic [19:0] a, input logic [31:0] w);
        pl_we = 1'b1; pl_addr = a; pl_word = w;
        tick();
        pl_we = 1'b0;
        model_write(a, w);
    endtask

    task automatic do_start(input logic [19:0] s, input logic [19:0] d, input logic [15:0] n);
        src = s; dst = d; len = n; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    // exp_cyc == 0 means only require that done_o appears within the budget.
    task automatic wait_done(input string tag, input int exp_cyc, input bit rand_gnt);
        int guard = 0;
        while (b_done !== 1'b1 && guard < 300) begin
            if (rand_gnt) gnt = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
        end
        gnt = 1'b1;
        if (exp_cyc > 0) chk(tag, cyc, exp_cyc);
        else             chk(tag, {31'd0, b_done}, 32'd1);
    endtask

    task automatic check_words_b(input string tag, input logic [19:0] base, input int n);
        logic [19:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 20'(4 * k);
            chk(tag, {ram_b[a + 20'd3], ram_b[a + 20'd2], ram_b[a + 20'd1], ram_b[a]}, word_b(a));
        end
    endtask

    task automatic check_words_s(input string tag, input logic [7:0] base, input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 8'(4 * k);
            chk(tag, {ram_s[a + 8'd3], ram_s[a + 8'd2], ram_s[a + 8'd1], ram_s[a]}, word_s(a));
        end
    endtask

    initial begin
        logic [19:0] rs, rd;
        int          rn;
        bit          done_seen;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b1;
        src = '0; dst = '0; len = '0; pl_we = 1'b0; pl_addr = '0; pl_word = '0;
        repeat (3) tick();
        chk("rst_en", {31'd0, b_en}, 32'd0);
        chk("rst_we", {28'd0, b_we}, 32'd0);
        chk("rst_addr", {12'd0, b_addr}, 32'd0);
        chk("rst_data", b_wdata, 32'd0);
        chk("rst_busy", {31'd0, b_busy}, 32'd0);
        chk("rst_done", {31'd0, b_done}, 32'd0);
        chk("rst_err", {31'd0, b_err}, 32'd0);
        chk("rst_count", {16'd0, b_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic two-word copy with gnt held high.
        preload(20'h100, 32'h11223344);
        preload(20'h104, 32'h55667788);
        do_start(20'h100, 20'h200, 16'd2);
        chk("c1_en", {31'd0, b_en}, 32'd1);
        chk("c1_we", {28'd0, b_we}, 32'd0);
        chk("c1_addr", {12'd0, b_addr}, 32'h100);
        chk("c1_busy", {31'd0, b_busy}, 32'd1);
        tick();
        chk("c2_we", {28'd0, b_we}, 32'hF);
        chk("c2_addr", {12'd0, b_addr}, 32'h200);
        chk("c2_data", b_wdata, 32'h11223344);
        tick();
        chk("c3_addr", {12'd0, b_addr}, 32'h104);
        tick();
        chk("c4_we", {28'd0, b_we}, 32'hF);
        chk("c4_addr", {12'd0, b_addr}, 32'h204);
        chk("c4_data", b_wdata, 32'h55667788);
        tick();
        chk("c5_done", {31'd0, b_done}, 32'd1);
        chk("c5_en", {31'd0, b_en}, 32'd0);
        tick();
        chk("c6_done", {31'd0, b_done}, 32'd0);
        chk("c6_busy", {31'd0, b_busy}, 32'd0);
        chk("c6_count", {16'd0, b_count}, 32'd2);
        chk("byte_200", {24'd0, ram_b[20'h200]}, 32'h44);
        chk("byte_207", {24'd0, ram_b[20'h207]}, 32'h55);
        model_copy(20'h100, 20'h200, 2);
        check_words_b("c_words", 20'h200, 2);

        // Misaligned start is rejected; zero-length start completes at once.
        do_start(20'h102, 20'h300, 16'd1);
        chk("err_pulse", {31'd0, b_err}, 32'd1);
        chk("err_en", {31'd0, b_en}, 32'd0);
        chk("err_busy", {31'd0, b_busy}, 32'd0);
        tick();
        chk("err_clear", {31'd0, b_err}, 32'd0);
        chk("err_en2", {31'd0, b_en}, 32'd0);
        chk("err_busy2", {31'd0, b_busy}, 32'd0);
        do_start(20'h100, 20'h300, 16'd0);
        chk("len0_done", {31'd0, b_done}, 32'd1);
        chk("len0_en", {31'd0, b_en}, 32'd0);
        tick();
        chk("len0_done2", {31'd0, b_done}, 32'd0);
        chk("len0_busy2", {31'd0, b_busy}, 32'd0);

        // Three-cycle grant stall during the second read.
        for (int k = 0; k < 3; k++) preload(20'h400 + 20'(4 * k), $urandom);
        do_start(20'h400, 20'h500, 16'd3);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("stall_addr", {12'd0, b_addr}, 32'h404);
            chk("stall_we", {28'd0, b_we}, 32'd0);
            gnt = 1'b0;
            tick();
        end
        gnt = 1'b1;
        chk("stall_addr_end", {12'd0, b_addr}, 32'h404);
        wait_done("stall_done_cyc", 10, 1'b0);
        tick();
        chk("stall_count", {16'd0, b_count}, 32'd3);
        model_copy(20'h400, 20'h500, 3);
        check_words_b("stall_words", 20'h500, 3);

        // Abort during the second granted write.
        for (int k = 0; k < 4; k++) preload(20'h600 + 20'(4 * k), $urandom);
        for (int k = 0; k < 4; k++) preload(20'h700 + 20'(4 * k), $urandom);
        do_start(20'h600, 20'h700, 16'd4);
        tick();
        tick();
        tick();
        chk("abort_we", {28'd0, b_we}, 32'hF);
        chk("abort_addr", {12'd0, b_addr}, 32'h704);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, b_busy}, 32'd0);
        chk("abort_en", {31'd0, b_en}, 32'd0);
        chk("abort_count", {16'd0, b_count}, 32'd2);
        done_seen = b_done;
        for (int k = 0; k < 4; k++) begin
            tick();
            done_seen = done_seen | b_done;
        end
        chk("abort_no_done", {31'd0, done_seen}, 32'd0);
        model_copy(20'h600, 20'h700, 2);
        check_words_b("abort_words", 20'h700, 4);

        // Address wrap on the 256-byte instance.
        preload(20'h0F8, $urandom);
        preload(20'h0FC, $urandom);
        preload(20'h100, $urandom);
        do_start(20'h0F8, 20'h040, 16'd3);
        repeat (4) tick();
        chk("wrap_addr", {24'd0, s_addr}, 32'h00);
        chk("wrap_en", {31'd0, s_en}, 32'd1);
        chk("wrap_we", {28'd0, s_we}, 32'd0);
        wait_done("wrap_done_cyc", 7, 1'b0);
        chk("wrap_s_done", {31'd0, s_done}, 32'd1);
        tick();
        chk("wrap_count", {16'd0, s_count}, 32'd3);
        model_copy(20'h0F8, 20'h040, 3);
        check_words_s("wrap_words", 8'h40, 3);

        // Reset in the middle of a read, then a clean copy.
        do_start(20'h100, 20'h800, 16'd2);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_en", {31'd0, b_en}, 32'd0);
        chk("mid_rst_addr", {12'd0, b_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, b_busy}, 32'd0);
        chk("mid_rst_count", {16'd0, b_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_start(20'h100, 20'h900, 16'd2);
        chk("post_rst_addr", {12'd0, b_addr}, 32'h100);
        wait_done("post_rst_done_cyc", 5, 1'b0);
        tick();
        chk("post_rst_count", {16'd0, b_count}, 32'd2);
        model_copy(20'h100, 20'h900, 2);
        check_words_b("post_rst_words", 20'h900, 2);

        // Random copies with random grant stalls (ranges may overlap).
        for (int it = 0; it < 6; it++) begin
            rs = 20'($urandom_range(0, 1023) * 4);
            rd = 20'($urandom_range(0, 1023) * 4);
            rn = $urandom_range(1, 8);
            for (int k = 0; k < rn; k++) preload(rs + 20'(4 * k), $urandom);
            do_start(rs, rd, 16'(rn));
            wait_done("rnd_done", 0, 1'b1);
            tick();
            chk("rnd_count", {16'd0, b_count}, 32'(rn));
            model_copy(rs, rd, rn);
            check_words_b("rnd_words", rd, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
